relu_pool: RTL and testbench
============================

# relu_pool

Post-accumulation stage that consumes packed partial-sum words drained from the output buffer (four 16-bit signed lanes per 64-bit word, raster order) and produces ReLU-activated, 2x2 max-pooled feature maps. It sits directly downstream of the output buffer/compare path. It writes packed pooled words to the next layer's input buffer through a valid/ready stream.

## Interface
Parameters:
- DW, 16: lane width (signed two's complement)
- COLS, 32: feature-map width in pixels; multiple of 8
- ROWS, 32: feature-map height in rows; even, ≥2

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_data  in  64  four pixels, lane0 = [63:48] (leftmost) … lane3 = [15:0]
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  64  four pooled pixels, lane0 = [63:48] leftmost
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts out_data
- plane_done  out  1  one-cycle pulse with the last output word of a plane

## Operation
- An input word is accepted when in_valid && in_ready. The output word is taken when out_valid && out_ready.
- ReLU is applied per lane: a negative value (MSB=1) becomes 0; all others pass unchanged.
- Horizontal pooling per word: h0 = max(r0,r1) and h1 = max(r2,r3), compared unsigned after ReLU.
- Counters:
  - word_col counts 0..COLS/4-1.
  - row counts 0..ROWS-1.
  - Both wrap to 0 at the end of a plane, so the next plane starts with no gap.
- FSM, two states:
  - EVEN (row[0]=0): {h0,h1} is written to line buffer entry word_col. Nothing is emitted.
  - ODD (row[0]=1): p0 = max(h0, lb[word_col].h0) and p1 = max(h1, lb[word_col].h1).
    - If word_col is even, {p0,p1} goes into the hold register.
    - If word_col is odd, out_data is loaded with {hold, p0, p1} and out_valid is set.
  - EVEN→ODD and ODD→EVEN transitions occur on acceptance of the last word of a row.
- in_ready = !out_valid || out_ready. A full output register blocks input; there is no skid buffer.
- plane_done goes high together with out_valid for the word produced by the last input of row ROWS-1. It stays high for exactly the cycle in which that word is first presented.
- Outputs per plane: (ROWS/2)·(COLS/8) words.

## Timing
- Reset values: out_data=0, out_valid=0, plane_done=0, state=EVEN, word_col=0, row=0, hold=0. in_ready is 1 after reset.
- Line buffer contents are not reset; every EVEN row rewrites all entries before they are read.
- Latency: out_valid rises in the cycle after the completing input word is accepted.
- Stall: while out_valid && !out_ready, out_data and out_valid hold steady and in_ready=0. plane_done does not re-pulse.
- Simultaneous drain and fill: if out_ready=1 and a completing word is accepted in the same cycle, out_data is replaced and out_valid stays 1.
- Reset mid-plane: counters, FSM and hold return to reset values. Any partial output is discarded. The next accepted word is treated as row 0, col 0.
- Input gaps (in_valid=0) do not advance any state.

## Structure
- Shared package cnn_pkg holds:
  - DW and LANES=4
  - lane slice constants
  - relu and max2 functions, which are reused by later layers
- Sub-module pool_line_buf: COLS/4 entries × 2·DW bits, single write port and asynchronous read port, indexed by word_col. Implemented as flops.
- The top holds the FSM, counters, hold register and output register.

## Test plan
- Single 4x8 plane, all positive, with pixel(r,c) = 8r+c: outputs {9,11,13,15} then {25,27,29,31}. plane_done is asserted on the second output word.
- Negative handling: row0 = all 0xFFFF, row1 = {0x8000,5,-3,2,…}. Pooled lanes give {5,2,…}, and all-negative windows give 0 (never 0xFFFF).
- Backpressure: hold out_ready=0 for 5 cycles after the first out_valid. out_data is stable, in_ready=0, and there is no lost or duplicated word once released. This is checked against a reference model across 2 planes.
- Random in_valid/out_ready: 70% and 50% duty cycles over 4 consecutive 32x32 planes. Each plane yields exactly 64 words, all matching the model, with 4 plane_done pulses.
- Reset asserted mid-row 3, word_col 2, then a fresh plane: output matches a clean-start plane exactly, with no residue from the hold register.
- Back-to-back throughput with out_ready=1: in_ready stays at 1 throughout. The output count per plane is (ROWS/2)·(COLS/8).

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared lane types and per-lane helpers for the CNN post-processing stages.
// The relu/max2 helpers are meant to be reused by later layers.
package cnn_pkg;

    localparam int DW    = 16;
    localparam int LANES = 4;

    typedef logic [DW-1:0] lane_t;

    // Horizontally pooled pair of pixels: h0 is the left one.
    typedef struct packed {
        lane_t h0;
        lane_t h1;
    } hpair_t;

    typedef enum logic {
        ST_EVEN = 1'b0,
        ST_ODD  = 1'b1
    } row_state_e;

    // Lane 0 is the leftmost pixel and occupies the most significant slice.
    localparam int LANE0_LO = (LANES - 1) * DW;
    localparam int LANE1_LO = (LANES - 2) * DW;
    localparam int LANE2_LO = (LANES - 3) * DW;
    localparam int LANE3_LO = (LANES - 4) * DW;

    function automatic int lane_lo(input int lane);
        return (LANES - 1 - lane) * DW;
    endfunction

    function automatic lane_t relu(input lane_t v);
        return v[DW-1] ? '0 : v;
    endfunction

    // Unsigned compare: operands are always non-negative after relu.
    function automatic lane_t max2(input lane_t a, input lane_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One row of horizontally pooled pairs, kept until the odd row below arrives.
// Single write port, asynchronous read port, both addressed by word column.
module pool_line_buf
    import cnn_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  hpair_t        wdata,
    output hpair_t        rdata
);

    hpair_t mem [DEPTH];

    // NOTE: storage is deliberately not reset; every entry is rewritten on the
    // even row before the odd row reads it, so a reset would only cost area.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/relu_pool.sv
// ReLU + 2x2 max-pool over packed 4-lane partial-sum words in raster order,
// emitting packed pooled words on a valid/ready stream.
module relu_pool #(
    parameter int DW   = 16,
    parameter int COLS = 32,
    parameter int ROWS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4*DW-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [4*DW-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            plane_done
);

    import cnn_pkg::*;

    localparam int WPR = COLS / 4;
    localparam int CW  = $clog2(WPR);
    localparam int RW  = (ROWS > 2) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0] LAST_COL = CW'(WPR - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    logic [CW-1:0] word_col;
    logic [RW-1:0] row;
    row_state_e    state;
    hpair_t        hold;

    lane_t  r [LANES];
    hpair_t h;
    hpair_t lb_rd;
    hpair_t p;
    logic   accept;
    logic   row_end;
    logic   plane_end;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign row_end   = (word_col == LAST_COL);
    assign plane_end = row_end && (row == LAST_ROW);

    // NOTE: every output of a combinational block gets a value on every path;
    // a missing assignment would infer a latch.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            r[i] = relu(in_data[lane_lo(i) +: DW]);
        end
        h.h0 = max2(r[0], r[1]);
        h.h1 = max2(r[2], r[3]);
        p.h0 = max2(h.h0, lb_rd.h0);
        p.h1 = max2(h.h1, lb_rd.h1);
    end

    pool_line_buf #(
        .DEPTH (WPR),
        .AW    (CW)
    ) u_line_buf (
        .clk   (clk),
        .we    (accept && (state == ST_EVEN)),
        .addr  (word_col),
        .wdata (h),
        .rdata (lb_rd)
    );

    // NOTE: registers are written with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_EVEN;
            word_col   <= '0;
            row        <= '0;
            hold       <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            plane_done <= 1'b0;
        end else begin
            // plane_done marks only the first cycle its word is presented.
            plane_done <= 1'b0;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                if (row_end) begin
                    word_col <= '0;
                    row      <= (row == LAST_ROW) ? '0 : row + 1'b1;
                    state    <= (state == ST_EVEN) ? ST_ODD : ST_EVEN;
                end else begin
                    word_col <= word_col + 1'b1;
                end

                if (state == ST_ODD) begin
                    if (word_col[0]) begin
                        out_data   <= {hold, p};
                        out_valid  <= 1'b1;
                        plane_done <= plane_end;
                    end else begin
                        hold <= p;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_relu_pool.sv
// Randomised scoreboard bench for relu_pool: a plane-level reference model
// predicts every pooled word; a monitor checks words as they are presented.
module tb_relu_pool;

    localparam int COLS = 32;
    localparam int ROWS = 32;
    localparam int WPR  = COLS / 4;
    localparam int WPP  = (ROWS / 2) * (COLS / 8);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        plane_done;

    relu_pool #(.DW(16), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plane_done (plane_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] pix [ROWS][COLS];

    int n_vec      = 0;
    int n_err      = 0;
    int valid_pct  = 100;
    int ready_pct  = 100;
    bit arm_stall  = 0;
    int stall_cnt  = 0;
    bit tput_mode  = 0;
    int pd_seen    = 0;
    int words_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pooled pixel = max of the four ReLU'd pixels in its window.
    function automatic int relu_i(input logic [15:0] v);
        return v[15] ? 0 : int'(v);
    endfunction

    function automatic logic [63:0] model_word(input int pr, input int wk);
        logic [63:0] w = '0;
        for (int j = 0; j < 4; j++) begin
            int pc = wk * 4 + j;
            int m  = 0;
            for (int a = 0; a < 2; a++)
                for (int b = 0; b < 2; b++)
                    if (relu_i(pix[2*pr+a][2*pc+b]) > m) m = relu_i(pix[2*pr+a][2*pc+b]);
            w[63-16*j -: 16] = m[15:0];
        end
        return w;
    endfunction

    // Sink readiness: random duty, with an optional forced 5-cycle stall.
    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else if (arm_stall && out_valid) begin
            arm_stall = 0;
            stall_cnt = 4;
            out_ready = 1'b0;
        end else begin
            out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: compare each presented word against the head of the queue.
    bit prev_stall = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
            words_seen = 0;
        end else begin
            if (plane_done) pd_seen++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", out_data, 64'hx);
                end else begin
                    check("out_data", out_data, exp_q[0].data);
                    if (!prev_stall) begin
                        check("plane_done", {63'd0, plane_done}, {63'd0, exp_q[0].last});
                        words_seen++;
                        if (exp_q[0].last) begin
                            check("words_per_plane", 64'(words_seen), 64'(WPP));
                            words_seen = 0;
                        end
                    end else begin
                        check("plane_done_stall", {63'd0, plane_done}, 64'd0);
                    end
                end
                if (out_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    prev_stall = 0;
                end else begin
                    check("in_ready_stall", {63'd0, in_ready}, 64'd0);
                    prev_stall = 1;
                end
            end else begin
                prev_stall = 0;
                check("plane_done_idle", {63'd0, plane_done}, 64'd0);
            end
            if (tput_mode) check("in_ready_tput", {63'd0, in_ready}, 64'd1);
        end
    end

    task automatic send_word(input logic [63:0] w);
        int guard = 0;
        bit acc   = 0;
        while ($urandom_range(99) >= valid_pct) begin
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (!acc) begin
                guard++;
                if (guard > 2000) begin
                    check("accept_timeout", 64'd0, 64'd1);
                    acc = 1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Drive a plane in raster order; stop before (stop_row, stop_wc) if reached.
    task automatic send_plane(input int stop_row, input int stop_wc);
        for (int r = 0; r < ROWS; r++) begin
            for (int wc = 0; wc < WPR; wc++) begin
                exp_t e;
                if (r == stop_row && wc == stop_wc) return;
                send_word({pix[r][4*wc], pix[r][4*wc+1], pix[r][4*wc+2], pix[r][4*wc+3]});
                if ((r % 2 == 1) && (wc % 2 == 1)) begin
                    e.data = model_word(r / 2, wc / 2);
                    e.last = (r == ROWS - 1) && (wc == WPR - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 || out_valid) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                check("drain_timeout", 64'(exp_q.size()), 64'd0);
                exp_q.delete();
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_plane_done", {63'd0, plane_done}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic fill_random();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                pix[r][c] = 16'($urandom);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_state();

        // Ramp plane, full throughput.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                pix[r][c] = 16'(8 * r + c);
        tput_mode = 1;
        send_plane(ROWS, 0);
        wait_drain();
        tput_mode = 0;

        // Negative handling plus backpressure on the first word.
        fill_random();
        for (int c = 0; c < COLS; c++) begin
            logic [15:0] pat [4];
            pat = '{16'h8000, 16'd5, 16'hFFFD, 16'd2};
            pix[0][c] = 16'hFFFF;
            pix[1][c] = pat[c % 4];
            pix[2][c] = 16'h8000 | 16'($urandom);
            pix[3][c] = 16'h8000 | 16'($urandom);
        end
        arm_stall = 1;
        send_plane(ROWS, 0);
        wait_drain();

        fill_random();
        arm_stall = 1;
        send_plane(ROWS, 0);
        wait_drain();

        // Random handshake duty over four back-to-back planes.
        valid_pct = 70;
        ready_pct = 50;
        for (int k = 0; k < 4; k++) begin
            fill_random();
            send_plane(ROWS, 0);
        end
        wait_drain();
        valid_pct = 100;
        ready_pct = 100;

        // Abort mid row 3 after word_col 2 has loaded the hold register.
        fill_random();
        send_plane(3, 3);
        wait_drain();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_state();
        send_plane(ROWS, 0);
        wait_drain();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("plane_done_count", 64'(pd_seen), 64'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
